// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier sequencer that borrows the shared datapath ALU for a truncated WIDTH x WIDTH product.
// Build option: define ALU_MUL_EARLY_EXIT_EN to finish as soon as no multiplier bits remain.
module alu_mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [1:0]       alu_aluk,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] mc_reg, mc_next;
  logic [WIDTH-1:0] mp_reg, mp_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] product_reg, product_next;

  logic             running;
  logic             last_step;
  logic [WIDTH-1:0] mc_gated;

  assign running = (state_reg == RUN);

`ifdef ALU_MUL_EARLY_EXIT_EN
  // Stop once the step just taken leaves no set multiplier bits to add.
  assign last_step = (cnt_reg == CNT_LAST) || (mp_reg[WIDTH-1:1] == '0);
`else
  assign last_step = (cnt_reg == CNT_LAST);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_partial
      assign mc_gated[gi] = mc_reg[gi] & mp_reg[0];
    end
  endgenerate

  assign ready    = (state_reg == IDLE);
  assign done     = (state_reg == DONE);
  assign product  = product_reg;
  assign alu_aluk = running ? ALUK_ADD : ALUK_PASSA;
  assign alu_a    = running ? acc_reg : '0;
  assign alu_b    = running ? mc_gated : '0;

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    mc_next      = mc_reg;
    mp_next      = mp_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mc_next    = mcand;
          mp_next    = mplier;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = alu_out;
        mc_next  = mc_reg << 1;
        mp_next  = mp_reg >> 1;
        cnt_next = cnt_reg + CW'(1);
        // The final sum is taken straight from the ALU so product is valid throughout DONE.
        if (last_step) begin
          state_next   = DONE;
          product_next = alu_out;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mc_reg      <= '0;
      mp_reg      <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      mc_reg      <= mc_next;
      mp_reg      <= mp_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: driver queues expected operations, a negedge monitor checks every cycle.
module tb_alu_mul_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] mcand = '0;
  logic [W-1:0] mplier = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] product;
  logic [1:0]   alu_aluk;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc_cyc;
    int           runs;
  } op_t;

  op_t          q[$];
  logic [W-1:0] held = '0;

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .ready(ready), .done(done), .product(product), .alu_aluk(alu_aluk),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared datapath ALU: ADD / AND / NOT / PASSA
  always_comb begin
    case (alu_aluk)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a & alu_b;
      2'b10:   alu_out = ~alu_a;
      default: alu_out = alu_a;
    endcase
  end

  function automatic logic [W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[W-1:0];
  endfunction

  function automatic int ref_runs(input logic [W-1:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int hb;
    hb = 0;
    for (int i = 0; i < W; i++) if (b[i]) hb = i;
    return hb + 1;
`else
    return W;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle outside reset, compare DUT outputs with the model of the oldest outstanding op.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
    end else if (q.size() == 0) begin
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_aluk", 32'(alu_aluk), 32'd3);
      chk("idle_alu_a", 32'(alu_a), 32'd0);
      chk("idle_alu_b", 32'(alu_b), 32'd0);
      chk("hold_product", 32'(product), 32'(held));
    end else begin
      op_t         op;
      int          s;
      logic [31:0] mask;
      logic [W-1:0] exp_acc, exp_b, exp_p;
      op = q[0];
      s  = cyc - op.acc_cyc;
      chk("busy_ready", 32'(ready), 32'd0);
      if (done) begin
        exp_p = ref_product(op.a, op.b);
        chk("done_latency", 32'(s), 32'(op.runs));
        chk("product", 32'(product), 32'(exp_p));
        $display("txn %04h x %04h -> %04h (expect %04h) done after %0d cycles",
                 op.a, op.b, product, exp_p, s + 1);
        held = exp_p;
        void'(q.pop_front());
      end else if (s >= op.runs) begin
        chk("done_late", 32'(done), 32'd1);
      end else begin
        mask    = (32'd1 << s) - 32'd1;
        exp_acc = ref_product(op.a, W'(32'(op.b) & mask));
        exp_b   = op.b[s] ? W'(32'(op.a) << s) : '0;
        chk("run_aluk", 32'(alu_aluk), 32'd0);
        chk("run_alu_a", 32'(alu_a), 32'(exp_acc));
        chk("run_alu_b", 32'(alu_b), 32'(exp_b));
        chk("run_product_hold", 32'(product), 32'(held));
      end
    end
  end

  // Waits for ready, presents the operands, and queues the expected op; start is dropped after acceptance.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    op_t op;
    bit  ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    op.a = a;
    op.b = b;
    op.acc_cyc = cyc + 1;
    op.runs = ref_runs(b);
    q.push_back(op);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_aluk", 32'(alu_aluk), 32'd3);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    do_mul(16'd3, 16'd5);
    do_mul(16'hFFFF, 16'hFFFF);
    do_mul(16'h0100, 16'h0100);

    // Start held high through RUN and DONE must not be taken until ready returns.
    do_mul(16'd7, 16'd9);
    start  = 1'b1;
    mcand  = 16'd2;
    mplier = 16'd2;
    do_mul(16'd2, 16'd2);

    // Abort in RUN cycle 8.
    do_mul(16'h00AB, 16'hFFCD);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_aluk", 32'(alu_aluk), 32'd3);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    do_mul(16'd4, 16'd4);

    do_mul(16'h1234, 16'd1);
    do_mul(16'h5A5A, 16'd0);
    do_mul(16'd1, 16'h8000);

    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom) & W'((32'd1 << $urandom_range(0, W)) - 32'd1);
      do_mul(ra, rb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_drain();
    // Operand inputs wander while idle; product and ALU drive must not move.
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      mcand  = W'($urandom);
      mplier = W'($urandom);
    end
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
